// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and types for the multi-port register file
package regfile_pkg;
    localparam int NREGS_DEF = 32;
    localparam int XLEN_DEF = 32;
    localparam int NRD_DEF = 2;
    typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;
    typedef logic [XLEN_DEF-1:0] reg_data_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits; alloc beats same-edge clear, rst beats both, r0 never busy
module regfile_scoreboard #(
    parameter int NREGS = 32,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_en,
    input  logic [AW-1:0]    alloc_addr,
    input  logic             clr0_en,
    input  logic [AW-1:0]    clr0_addr,
    input  logic             clr1_en,
    input  logic [AW-1:0]    clr1_addr,
    output logic [NREGS-1:0] busy_vec
);
    always_ff @(posedge clk)
        for (int r = 0; r < NREGS; r++)
            busy_vec[r] <= !rst && r != 0 &&
                ((alloc_en && alloc_addr == AW'(r)) ||
                 (busy_vec[r] && !(clr0_en && clr0_addr == AW'(r)) && !(clr1_en && clr1_addr == AW'(r))));
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read, dual-write register file with busy scoreboard
// REGFILE_BYPASS_EN: reads see same-cycle write data (wr1 priority) and report not busy
module regfile_mp import regfile_pkg::*; #(
    parameter int NREGS = NREGS_DEF,
    parameter int XLEN = XLEN_DEF,
    parameter int NRD = NRD_DEF,
    localparam int AW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              wr0_en,
    input  logic [AW-1:0]     wr0_addr,
    input  logic [XLEN-1:0]   wr0_data,
    input  logic              wr1_en,
    input  logic [AW-1:0]     wr1_addr,
    input  logic [XLEN-1:0]   wr1_data,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr,
    output logic [NREGS-1:0]  busy_vec
);
    logic [XLEN-1:0] regs [NREGS];
    logic w0, w1;
    assign w0 = wr0_en && wr0_addr != '0;
    assign w1 = wr1_en && wr1_addr != '0;
    // wr1 is applied last so it wins on an address collision
    always_ff @(posedge clk)
        if (rst)
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        else begin
            if (w0) regs[wr0_addr] <= wr0_data;
            if (w1) regs[wr1_addr] <= wr1_data;
        end
    regfile_scoreboard #(.NREGS(NREGS)) u_sb (
        .clk(clk), .rst(rst),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .clr0_en(w0), .clr0_addr(wr0_addr),
        .clr1_en(w1), .clr1_addr(wr1_addr),
        .busy_vec(busy_vec)
    );
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] a;
        assign a = rd_addr[p*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        logic b0, b1;
        assign b0 = w0 && wr0_addr == a;
        assign b1 = w1 && wr1_addr == a;
        assign rd_data[p*XLEN +: XLEN] = b1 ? wr1_data : b0 ? wr0_data : regs[a];
        assign rd_busy[p] = busy_vec[a] && !(b0 || b1);
`else
        assign rd_data[p*XLEN +: XLEN] = regs[a];
        assign rd_busy[p] = busy_vec[a];
`endif
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and randomized checks of regfile_mp against an array-based model
module tb_regfile_mp;
    import regfile_pkg::*;
    localparam int NREGS = 32, XLEN = 32, NRD = 2, AW = 5;
    logic clk = 0, rst = 1;
    logic [NRD*AW-1:0] rd_addr = '0;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0] rd_busy;
    logic wr0_en = 0, wr1_en = 0, alloc_en = 0;
    reg_addr_t wr0_addr = '0, wr1_addr = '0, alloc_addr = '0;
    reg_data_t wr0_data = '0, wr1_data = '0;
    logic [NREGS-1:0] busy_vec;
    int errors = 0, checks = 0;
    reg_data_t m_regs [NREGS];
    logic [NREGS-1:0] m_busy;

    always #5 clk = ~clk;

    regfile_mp #(.NREGS(NREGS), .XLEN(XLEN), .NRD(NRD)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_vec(busy_vec)
    );

    function automatic reg_data_t exp_data(reg_addr_t a);
`ifdef REGFILE_BYPASS_EN
        if (a != 0 && wr1_en && wr1_addr == a) return wr1_data;
        if (a != 0 && wr0_en && wr0_addr == a) return wr0_data;
`endif
        return a == 0 ? '0 : m_regs[a];
    endfunction

    function automatic logic exp_busy(reg_addr_t a);
`ifdef REGFILE_BYPASS_EN
        if (a != 0 && ((wr1_en && wr1_addr == a) || (wr0_en && wr0_addr == a))) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    task automatic step();
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_busy = '0;
        end else begin
            if (wr0_en && wr0_addr != 0) begin m_regs[wr0_addr] = wr0_data; m_busy[wr0_addr] = 1'b0; end
            if (wr1_en && wr1_addr != 0) begin m_regs[wr1_addr] = wr1_data; m_busy[wr1_addr] = 1'b0; end
            if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr0_en = 0; wr1_en = 0; alloc_en = 0; rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; wr0_en = 1; wr0_addr = 5'd2; wr0_data = 32'h1; alloc_en = 1; alloc_addr = 5'd2;
        step();
        idle();
        for (int r = 0; r < NREGS; r++) begin
            rd_addr = {AW'(r), AW'(r)};
            #1;
            for (int p = 0; p < NRD; p++) begin
                checks++;
                if (rd_data[p*XLEN +: XLEN] !== '0 || rd_busy[p] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_read r%0d p%0d: got %h busy %b want 0 busy 0", r, p, rd_data[p*XLEN +: XLEN], rd_busy[p]);
                end
            end
        end
        checks++;
        if (busy_vec !== '0) begin errors++; $display("FAIL reset_busy_vec: got %h want 0", busy_vec); end
    endtask

    task automatic test_write();
        wr0_en = 1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
        step();
        idle();
        rd_addr = {5'd0, 5'd5};
        #1;
        checks++;
        if (rd_data[XLEN-1:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL write_r5: got %h want deadbeef", rd_data[XLEN-1:0]); end
        wr0_en = 1; wr0_addr = 5'd0; wr0_data = 32'h1234;
        step();
        idle();
        #1;
        checks++;
        if (rd_data[2*XLEN-1:XLEN] !== '0) begin errors++; $display("FAIL write_r0: got %h want 0", rd_data[2*XLEN-1:XLEN]); end
    endtask

    task automatic test_dual_write();
        wr0_en = 1; wr0_addr = 5'd7; wr0_data = 32'h11;
        wr1_en = 1; wr1_addr = 5'd7; wr1_data = 32'h22;
        step();
        idle();
        rd_addr = {5'd7, 5'd7};
        #1;
        checks++;
        if (rd_data[XLEN-1:0] !== 32'h22) begin errors++; $display("FAIL dual_write_r7: got %h want 22", rd_data[XLEN-1:0]); end
    endtask

    task automatic test_alloc();
        alloc_en = 1; alloc_addr = 5'd3;
        step();
        idle();
        rd_addr = {5'd3, 5'd0};
        #1;
        checks++;
        if (rd_busy[1] !== 1'b1 || busy_vec[3] !== 1'b1) begin errors++; $display("FAIL alloc_busy: got %b/%b want 1/1", rd_busy[1], busy_vec[3]); end
        wr0_en = 1; wr0_addr = 5'd3; wr0_data = 32'h55;
        step();
        idle();
        #1;
        checks++;
        if (rd_busy[1] !== 1'b0 || rd_data[2*XLEN-1:XLEN] !== 32'h55) begin
            errors++; $display("FAIL alloc_clear: got busy %b data %h want 0 55", rd_busy[1], rd_data[2*XLEN-1:XLEN]);
        end
        alloc_en = 1; alloc_addr = 5'd3; wr0_en = 1; wr0_addr = 5'd3; wr0_data = 32'h66;
        step();
        idle();
        #1;
        checks++;
        if (rd_busy[1] !== 1'b1 || rd_data[2*XLEN-1:XLEN] !== 32'h66) begin
            errors++; $display("FAIL alloc_and_write: got busy %b data %h want 1 66", rd_busy[1], rd_data[2*XLEN-1:XLEN]);
        end
        alloc_en = 1; alloc_addr = 5'd3;
        step();
        idle();
        #1;
        checks++;
        if (busy_vec[3] !== 1'b1) begin errors++; $display("FAIL realloc_busy: got %b want 1", busy_vec[3]); end
        alloc_en = 1; alloc_addr = 5'd0;
        step();
        idle();
        #1;
        checks++;
        if (busy_vec[0] !== 1'b0) begin errors++; $display("FAIL alloc_r0: got %b want 0", busy_vec[0]); end
    endtask

    task automatic test_bypass();
        reg_data_t want_d;
        logic want_b;
        wr0_en = 1; wr0_addr = 5'd9; wr0_data = 32'h1111;
        step();
        idle();
        alloc_en = 1; alloc_addr = 5'd9;
        step();
        idle();
        wr1_en = 1; wr1_addr = 5'd9; wr1_data = 32'hA5A5;
        rd_addr = {5'd9, 5'd0};
        #1;
`ifdef REGFILE_BYPASS_EN
        want_d = 32'hA5A5; want_b = 1'b0;
`else
        want_d = 32'h1111; want_b = 1'b1;
`endif
        checks++;
        if (rd_data[2*XLEN-1:XLEN] !== want_d || rd_busy[1] !== want_b) begin
            errors++; $display("FAIL bypass_same_cycle: got %h busy %b want %h busy %b", rd_data[2*XLEN-1:XLEN], rd_busy[1], want_d, want_b);
        end
        step();
        idle();
        #1;
        checks++;
        if (rd_data[2*XLEN-1:XLEN] !== 32'hA5A5 || rd_busy[1] !== 1'b0) begin
            errors++; $display("FAIL bypass_after: got %h busy %b want a5a5 busy 0", rd_data[2*XLEN-1:XLEN], rd_busy[1]);
        end
    endtask

    task automatic test_reset_mid();
        wr0_en = 1; wr0_addr = 5'd6; wr0_data = 32'h99; alloc_en = 1; alloc_addr = 5'd8;
        step();
        idle();
        rst = 1; alloc_en = 1; alloc_addr = 5'd4; wr0_en = 1; wr0_addr = 5'd6; wr0_data = 32'h77;
        step();
        idle();
        rd_addr = {5'd4, 5'd6};
        #1;
        checks++;
        if (busy_vec !== '0) begin errors++; $display("FAIL reset_mid_busy: got %h want 0", busy_vec); end
        checks++;
        if (rd_data[XLEN-1:0] !== '0 || rd_busy[1] !== 1'b0) begin
            errors++; $display("FAIL reset_mid_r6: got %h busy %b want 0 busy 0", rd_data[XLEN-1:0], rd_busy[1]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst = $urandom_range(0, 40) == 0;
            wr0_en = $urandom_range(0, 1); wr0_addr = AW'($urandom); wr0_data = $urandom;
            wr1_en = $urandom_range(0, 1); wr1_addr = $urandom_range(0, 3) == 0 ? wr0_addr : AW'($urandom); wr1_data = $urandom;
            alloc_en = $urandom_range(0, 1); alloc_addr = $urandom_range(0, 3) == 0 ? wr0_addr : AW'($urandom);
            rd_addr = $urandom_range(0, 3) == 0 ? {wr1_addr, wr0_addr} : NRD*AW'($urandom);
            #1;
            for (int p = 0; p < NRD; p++) begin
                checks++;
                if (rd_data[p*XLEN +: XLEN] !== exp_data(rd_addr[p*AW +: AW]) || rd_busy[p] !== exp_busy(rd_addr[p*AW +: AW])) begin
                    errors++;
                    $display("FAIL random_read i%0d p%0d: got %h busy %b want %h busy %b", i, p, rd_data[p*XLEN +: XLEN], rd_busy[p],
                             exp_data(rd_addr[p*AW +: AW]), exp_busy(rd_addr[p*AW +: AW]));
                end
            end
            checks++;
            if (busy_vec !== m_busy) begin errors++; $display("FAIL random_busy_vec i%0d: got %h want %h", i, busy_vec, m_busy); end
            step();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write();
        test_dual_write();
        test_alloc();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
